// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fifo_rd_stream: drains an async-FIFO read port into a 2-entry skid      |
// | buffer and presents a registered valid/ready stream.  Rev 1.0           |
// +------------------------------------------------------------------------+
module fifo_rd_stream #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [DATA_SIZE-1:0] rdata,
  input  logic                 rempty,
  output logic                 rinc,
  input  logic                 flush,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [1:0]           r_count;
  logic [DATA_SIZE-1:0] r_s0;
  logic [DATA_SIZE-1:0] r_s1;
  logic [CNT_WIDTH-1:0] r_xfer;
  logic                 w_pop;
  logic                 w_deq;

  // Pop decision looks only at local occupancy, never at out_ready.
  assign w_pop = !rempty && (r_count != c_FULL) && !flush && !rrst;
  assign w_deq = (r_count != c_EMPTY) && out_ready;

  assign rinc      = w_pop;
  assign out_data  = r_s0;
  assign out_valid = (r_count != c_EMPTY);
  assign occupancy = r_count;
  assign xfer_cnt  = r_xfer;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_count <= c_EMPTY;
      r_s0    <= '0;
      r_s1    <= '0;
      r_xfer  <= '0;
    end else begin
      if (w_deq) begin
        r_xfer <= r_xfer + CNT_WIDTH'(1);
      end
      if (flush) begin
        r_count <= c_EMPTY;
      end else begin
        case (r_count)
          c_EMPTY: begin
            if (w_pop) begin
              r_s0    <= rdata;
              r_count <= c_ONE;
            end
          end
          c_ONE: begin
            if (w_pop && w_deq) begin
              r_s0 <= rdata;
            end else if (w_pop) begin
              r_s1    <= rdata;
              r_count <= c_FULL;
            end else if (w_deq) begin
              r_count <= c_EMPTY;
            end
          end
          c_FULL: begin
            if (w_deq) begin
              r_s0    <= r_s1;
              r_count <= c_ONE;
            end
          end
          default: r_count <= c_EMPTY;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// Directed bench for fifo_rd_stream: vector table plus streaming/wrap sequences.
module tb_fifo_rd_stream;

  logic       clk;
  logic       rrst;
  logic [7:0] rdata;
  logic       rempty;
  logic       flush;
  logic       out_ready;

  logic        rinc,  w_rinc;
  logic [7:0]  out_data, w_out_data;
  logic        out_valid, w_out_valid;
  logic [1:0]  occupancy, w_occupancy;
  logic [15:0] xfer_cnt;
  logic [3:0]  w_xfer_cnt;

  int total  = 0;
  int passed = 0;

  fifo_rd_stream #(.DATA_SIZE(8), .CNT_WIDTH(16)) dut (
    .rclk(clk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DATA_SIZE(8), .CNT_WIDTH(4)) dut_w (
    .rclk(clk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(w_rinc),
    .flush(flush), .out_data(w_out_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .occupancy(w_occupancy), .xfer_cnt(w_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       chk;
    logic       rst;
    logic       empty;
    logic [7:0] data;
    logic       fl;
    logic       rdy;
    logic       e_rinc;
    logic       e_valid;
    logic [7:0] e_data;
    logic [1:0] e_occ;
    int         e_cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic rst, input logic empty, input logic [7:0] data,
                       input logic fl, input logic rdy);
    @(negedge clk);
    rrst = rst; rempty = empty; rdata = data; flush = fl; out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  // Feed n words 1..n with out_ready held high; one transfer per cycle after 1-cycle latency.
  task automatic stream(input int n, input string tag);
    for (int i = 0; i <= n + 1; i++) begin
      drive(1'b0, (i < n) ? 1'b0 : 1'b1, 8'(i + 1), 1'b0, 1'b1);
      check({tag, "_rinc"}, rinc, (i < n) ? 1 : 0);
      if (i >= 1 && i <= n) begin
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, i);
        check({tag, "_occ"}, occupancy, 1);
      end else begin
        check({tag, "_valid"}, out_valid, 0);
      end
      check({tag, "_cnt"}, xfer_cnt, (i == 0) ? 0 : i - 1);
      check({tag, "_cnt4"}, w_xfer_cnt, (i == 0) ? 0 : (i - 1) % 16);
    end
  endtask

  initial begin
    rrst = 1'b1; rempty = 1'b1; rdata = '0; flush = 1'b0; out_ready = 1'b0;

    //        chk rst emp data  fl rdy  rinc val edata occ cnt
    vecs[0]  = '{0, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 1, 0, 8'h5A, 0, 0, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{1, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0};
    vecs[3]  = '{1, 0, 0, 8'hA5, 0, 0, 1, 0, 8'h00, 0, 0};
    vecs[4]  = '{1, 0, 1, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0};
    vecs[5]  = '{1, 0, 1, 8'h00, 0, 1, 0, 1, 8'hA5, 1, 0};
    vecs[6]  = '{1, 0, 1, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 1};
    vecs[7]  = '{1, 0, 0, 8'h01, 0, 0, 1, 0, 8'hA5, 0, 1};
    vecs[8]  = '{1, 0, 0, 8'h02, 0, 0, 1, 1, 8'h01, 1, 1};
    vecs[9]  = '{1, 0, 0, 8'h03, 0, 0, 0, 1, 8'h01, 2, 1};
    vecs[10] = '{1, 0, 0, 8'h03, 0, 0, 0, 1, 8'h01, 2, 1};
    vecs[11] = '{1, 0, 0, 8'h03, 0, 1, 0, 1, 8'h01, 2, 1};
    vecs[12] = '{1, 0, 0, 8'h03, 0, 1, 1, 1, 8'h02, 1, 2};
    vecs[13] = '{1, 0, 1, 8'h00, 0, 1, 0, 1, 8'h03, 1, 3};
    vecs[14] = '{1, 0, 1, 8'h00, 0, 0, 0, 0, 8'h03, 0, 4};
    vecs[15] = '{1, 0, 0, 8'h11, 0, 0, 1, 0, 8'h03, 0, 4};
    vecs[16] = '{1, 0, 0, 8'h22, 0, 0, 1, 1, 8'h11, 1, 4};
    vecs[17] = '{1, 0, 0, 8'h33, 1, 1, 0, 1, 8'h11, 2, 4};
    vecs[18] = '{1, 0, 0, 8'h33, 0, 0, 1, 0, 8'h11, 0, 5};
    vecs[19] = '{1, 0, 1, 8'h00, 0, 1, 0, 1, 8'h33, 1, 5};
    vecs[20] = '{1, 0, 1, 8'h00, 0, 0, 0, 0, 8'h33, 0, 6};

    for (int v = 0; v < 21; v++) begin
      drive(vecs[v].rst, vecs[v].empty, vecs[v].data, vecs[v].fl, vecs[v].rdy);
      if (vecs[v].chk) begin
        check($sformatf("v%0d_rinc", v),  rinc,      vecs[v].e_rinc);
        check($sformatf("v%0d_valid", v), out_valid, vecs[v].e_valid);
        check($sformatf("v%0d_data", v),  out_data,  vecs[v].e_data);
        check($sformatf("v%0d_occ", v),   occupancy, vecs[v].e_occ);
        check($sformatf("v%0d_cnt", v),   xfer_cnt,  vecs[v].e_cnt);
      end
    end

    do_reset();
    stream(16, "stream");
    check("stream_final_cnt", xfer_cnt, 16);

    do_reset();
    stream(17, "wrap");
    check("wrap_final_cnt16", xfer_cnt, 17);
    check("wrap_final_cnt4", w_xfer_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer stage for the asynchronous FIFO. It drains the FIFO's read port (rdata/rempty/rinc) in the rclk domain and re-presents the words as a registered valid/ready stream. A 2-entry skid buffer sustains one word per cycle with no combinational path from out_ready to rinc. It also provides a synchronous flush and a wrapping transfer counter.

Parameters:
DATA_SIZE, 8, word width; matches FIFO DATA_SIZE.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
rclk  input  1  read-domain clock; all logic is rising-edge.
rrst  input  1  synchronous reset, active-high.
rdata  input  DATA_SIZE  FIFO read data; valid combinationally whenever rempty=0.
rempty  input  1  FIFO empty flag.
rinc  output  1  FIFO read-increment (pop).
flush  input  1  synchronous discard of buffered words; FIFO contents untouched.
out_data  output  DATA_SIZE  stream data (head of buffer, registered).
out_valid  output  1  stream valid.
out_ready  input  1  downstream ready.
occupancy  output  2  words held in buffer, 0..2.
xfer_cnt  output  CNT_WIDTH  count of accepted stream words (out_valid & out_ready), wraps.

Behaviour:
- Interface: one clock (rclk); reset rrst is synchronous and active-high.
- Storage: slots s0 (head) and s1; count in 0..2. out_data = s0, out_valid = (count != 0), occupancy = count.
- rinc is combinational: rinc = !rempty & (count < 2) & !flush & !rrst. It never depends on out_ready.
- pop = rinc, and rdata is captured at that edge. deq = out_valid & out_ready.
- Per-edge update (no flush):
  - count0: pop writes s0, count becomes 1.
  - count1, pop & deq: s0 is loaded with rdata, count stays 1.
  - count1, pop only: rdata goes to s1, count becomes 2.
  - count1, deq only: count becomes 0.
  - count2, deq: s0 is loaded from s1, count becomes 1. pop is impossible at count2.
  - count2, no deq: hold.
- Ordering: strict FIFO order. No word is duplicated or lost except by flush.
- Latency: a word visible with rempty=0 at cycle N while count<2 is popped at the end of N and appears on out_data/out_valid in N+1.
- Throughput: in steady state with out_ready=1 and FIFO non-empty, count sits at 1 and one word transfers per cycle.
- Backpressure: with out_ready=0 the buffer fills to 2 and rinc drops. out_data/out_valid stay stable until accepted.
- flush=1 at an edge:
  - count becomes 0 and no pop occurs (rinc=0 that cycle).
  - A deq in the same cycle still counts in xfer_cnt. Handshake completed = counted.
  - out_valid=0 the next cycle.
- xfer_cnt increments by 1 on every deq and wraps modulo 2^CNT_WIDTH. It is cleared only by rrst.
- Reset (rrst=1 at an edge):
  - count=0, out_valid=0, out_data=0, s1=0, occupancy=0, xfer_cnt=0.
  - rinc is held 0 while rrst=1.
  - Reset mid-transfer discards buffered words. FIFO pointer state belongs to the FIFO's own resets.
- s0/s1 are not cleared on flush; only count is cleared. out_data is don't-care while out_valid=0, except after rrst, where it is 0.

Test Plan:
1. Reset then idle: rrst=1 for 2 cycles, rempty=1 -> out_valid=0, out_data=0, occupancy=0, xfer_cnt=0, rinc=0 throughout.
2. Single word: rempty=0 with rdata=8'hA5 for one cycle, out_ready=0 -> rinc=1 that cycle; next cycle out_valid=1, out_data=A5, occupancy=1. Then out_ready=1 -> one cycle later out_valid=0, xfer_cnt=1.
3. Streaming: FIFO supplies 8'h01..8'h10, out_ready=1 -> out_data 01..10 on 16 consecutive cycles after 1-cycle latency; occupancy stays 1; xfer_cnt=16.
4. Backpressure: stream 01,02,03 with out_ready=0 -> occupancy reaches 2, rinc=0 with rempty=0, out_data holds 01. Release out_ready -> 01,02,03 delivered in order with no duplication.
5. Flush: occupancy=2 (words 11,22), assert flush one cycle with out_ready=1 -> rinc=0 that cycle; next cycle occupancy=0, out_valid=0; xfer_cnt=+1 (word 11 accepted). Next FIFO word 33 is then delivered.
6. Counter wrap with CNT_WIDTH=4: deliver 17 words -> xfer_cnt reads 15 after word 15, 0 after word 16, 1 after word 17.
